pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_load_use_detect.sv | 27 ++
 rtl/pipeline_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BOOT     = 3'd1,
    ST_RUN      = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_HALTED   = 3'd5
  } state_e;

  // Drain length after a halt: pipeline depth minus one
  localparam int DRAIN_CYCLES_DEFAULT = 4;

  // Architectural register index width
  localparam int REG_IDX_W = 5;

endpackage : pipeline_ctrl_pkg

`default_nettype wire

// File: rtl/pipeline_load_use_detect.sv
// ---------------------------------------------------------------------------
// pipeline_load_use_detect
// Combinational load-use hazard compare between the EX load and ID sources.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                 exMemRead_i,
  input  logic [REG_IDX_W-1:0] exRd_i,
  input  logic [REG_IDX_W-1:0] idRs_i,
  input  logic [REG_IDX_W-1:0] idRt_i,
  output logic                 loadUse_o
);

  // r0 is hard-wired zero, so a load targeting it never creates a hazard
  always_comb begin
    loadUse_o = exMemRead_i
             && (exRd_i != '0)
             && ((exRd_i == idRs_i) || (exRd_i == idRt_i));
  end

endmodule : pipeline_load_use_detect

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
// Boot / run / memory-wait / drain / halt control for a 5-stage pipeline.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      startAddress,
  input  logic                   haltReq,
  input  logic                   exMemRead,
  input  logic [REG_IDX_W-1:0]   exRd,
  input  logic [REG_IDX_W-1:0]   idRs,
  input  logic [REG_IDX_W-1:0]   idRt,
  input  logic                   branchTaken,
  input  logic [ADDR_W-1:0]      branchTarget,
  input  logic                   memReady,
  output logic                   pcSelect,
  output logic [ADDR_W-1:0]      pcLoadAddress,
  output logic                   pcWrite,
  output logic                   ifidWrite,
  output logic                   ifidFlush,
  output logic                   idexFlush,
  output logic                   pipeEn,
  output logic                   running,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stallCount
);

  // Counter must hold DRAIN_CYCLES-1
  localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e                 state_q, state_d;
  state_e                 saved_q, saved_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   loadUse;

  pipeline_load_use_detect u_load_use (
    .exMemRead_i (exMemRead),
    .exRd_i      (exRd),
    .idRs_i      (idRs),
    .idRt_i      (idRt),
    .loadUse_o   (loadUse)
  );

  // State and bookkeeping registers; reset wins over every other request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  // Next-state and output decode; events in RUN resolve as
  // memory stall > branch > halt > load-use
  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    addr_d        = addr_q;
    drain_d       = drain_q;
    stall_d       = stall_q;
    pcSelect      = 1'b0;
    pcLoadAddress = '0;
    pcWrite       = 1'b0;
    ifidWrite     = 1'b0;
    ifidFlush     = 1'b0;
    idexFlush     = 1'b0;
    pipeEn        = 1'b0;
    running       = 1'b0;
    halted        = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        halted = (state_q == ST_HALTED);
        if (start) begin
          addr_d  = startAddress;
          state_d = ST_BOOT;
        end
      end

      ST_BOOT: begin
        pcSelect      = 1'b1;
        pcLoadAddress = addr_q;
        pcWrite       = 1'b1;
        pipeEn        = 1'b1;
        ifidFlush     = 1'b1;
        idexFlush     = 1'b1;
        state_d       = ST_RUN;
      end

      ST_RUN: begin
        running   = 1'b1;
        pipeEn    = 1'b1;
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        if (!memReady) begin
          pipeEn    = 1'b0;
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          saved_d   = ST_RUN;
          state_d   = ST_MEM_WAIT;
        end else if (branchTaken) begin
          pcSelect      = 1'b1;
          pcLoadAddress = branchTarget;
          ifidFlush     = 1'b1;
          idexFlush     = 1'b1;
        end else if (haltReq) begin
          pcWrite   = 1'b0;
          ifidFlush = 1'b1;
          drain_d   = DRAIN_LOAD;
          state_d   = ST_DRAIN;
        end else if (loadUse) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          idexFlush = 1'b1;
          if (stall_q != '1) begin
            stall_d = stall_q + STALL_CNT_W'(1);
          end
        end
      end

      ST_MEM_WAIT: begin
        // Pipeline frozen; resume where we came from once memory is ready
        if (memReady) begin
          state_d = saved_q;
        end
      end

      ST_DRAIN: begin
        if (!memReady) begin
          saved_d = ST_DRAIN;
          state_d = ST_MEM_WAIT;
        end else begin
          pipeEn    = 1'b1;
          ifidWrite = 1'b1;
          ifidFlush = 1'b1;
          if (drain_q == '0) begin
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stallCount = stall_q;

endmodule : pipeline_sequencer

`default_nettype wire
